// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: one CPU access at a time, memory-mapped I/O page
// (KBSR/KBDR/DSR/DDR/MCR) served locally, every other address forwarded to RAM
// over a cs / r_w / ready handshake. Returns read data and a one-cycle R strobe.
module lc3_mem_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_en,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_r,
   output logic                  ram_cs,
   output logic                  ram_r_w,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic                  ram_ready,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   input  logic                  kbd_valid,
   input  logic [7:0]            kbd_char,
   output logic                  kbd_irq,
   input  logic                  disp_ready,
   output logic                  ddr_valid,
   output logic [7:0]            ddr_char,
   output logic                  mcr_run
);

   localparam logic [ADDR_WIDTH-1:0] KBSR_ADDR = ADDR_WIDTH'(16'hFE00);
   localparam logic [ADDR_WIDTH-1:0] KBDR_ADDR = ADDR_WIDTH'(16'hFE02);
   localparam logic [ADDR_WIDTH-1:0] DSR_ADDR  = ADDR_WIDTH'(16'hFE04);
   localparam logic [ADDR_WIDTH-1:0] DDR_ADDR  = ADDR_WIDTH'(16'hFE06);
   localparam logic [ADDR_WIDTH-1:0] MCR_ADDR  = ADDR_WIDTH'(16'hFFFE);
   localparam logic [DATA_WIDTH-1:0] MCR_RESET = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                state, next_state;
   logic                  accept;
   logic                  sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr, is_dev;
   logic [DATA_WIDTH-1:0] dev_rdata;

   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_we;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  kb_rdy, kb_ie;
   logic [7:0]            kb_char;
   logic [DATA_WIDTH-1:0] mcr;

   // Address decode of the live MAR and read mux for the device registers
   always_comb begin
      sel_kbsr  = (mem_addr == KBSR_ADDR);
      sel_kbdr  = (mem_addr == KBDR_ADDR);
      sel_dsr   = (mem_addr == DSR_ADDR);
      sel_ddr   = (mem_addr == DDR_ADDR);
      sel_mcr   = (mem_addr == MCR_ADDR);
      is_dev    = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr | sel_mcr;
      dev_rdata = '0;
      if (sel_kbsr) begin
         dev_rdata[DATA_WIDTH-1] = kb_rdy;
         dev_rdata[DATA_WIDTH-2] = kb_ie;
      end else if (sel_kbdr) begin
         dev_rdata = DATA_WIDTH'(kb_char);
      end else if (sel_dsr) begin
         dev_rdata[DATA_WIDTH-1] = disp_ready;
      end else if (sel_mcr) begin
         dev_rdata = mcr;
      end
   end

   // Next-state logic and state-decoded handshake outputs
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      ram_cs     = 1'b0;
      mem_r      = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_en) begin
               accept     = 1'b1;
               next_state = is_dev ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            // ready may still reflect an older access, so it is not looked at here
            ram_cs     = 1'b1;
            next_state = S_WAIT;
         end
         S_WAIT: begin
            ram_cs = 1'b1;
            if (ram_ready) next_state = S_RESP;
         end
         S_RESP: begin
            mem_r      = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Latch the accepted request; it drives the RAM side for the whole access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_addr  <= '0;
         req_we    <= 1'b0;
         req_wdata <= '0;
      end else if (accept) begin
         req_addr  <= mem_addr;
         req_we    <= mem_we;
         req_wdata <= mem_wdata;
      end
   end

   // Read data: device value at acceptance, or RAM word when ready arrives in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rdata <= '0;
      end else if (accept && is_dev && !mem_we) begin
         mem_rdata <= dev_rdata;
      end else if (state == S_WAIT && ram_ready) begin
         mem_rdata <= ram_data_out;
      end
   end

   // Keyboard status/data: a new character wins over a coincident KBDR read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kb_rdy  <= 1'b0;
         kb_ie   <= 1'b0;
         kb_char <= '0;
      end else begin
         if (kbd_valid) begin
            kb_rdy  <= 1'b1;
            kb_char <= kbd_char;
         end else if (accept && sel_kbdr && !mem_we) begin
            kb_rdy <= 1'b0;
         end
         if (accept && sel_kbsr && mem_we) kb_ie <= mem_wdata[DATA_WIDTH-2];
      end
   end

   // Machine control register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        mcr <= MCR_RESET;
      else if (accept && sel_mcr && mem_we) mcr <= mem_wdata;
   end

   // Display data: a DDR write produces a pulse coinciding with the RESP cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ddr_valid <= 1'b0;
         ddr_char  <= '0;
      end else begin
         ddr_valid <= accept && sel_ddr && mem_we;
         if (accept && sel_ddr && mem_we) ddr_char <= mem_wdata[7:0];
      end
   end

   assign ram_addr    = req_addr;
   assign ram_data_in = req_wdata;
   assign ram_r_w     = req_we;
   assign kbd_irq     = kb_rdy & kb_ie;
   assign mcr_run     = mcr[DATA_WIDTH-1];

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed self-checking bench for lc3_mem_ctrl with a registered-ready RAM model.
module tb_lc3_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_en = 1'b0;
   logic        mem_we = 1'b0;
   logic [15:0] mem_addr = '0;
   logic [15:0] mem_wdata = '0;
   logic [15:0] mem_rdata;
   logic        mem_r;
   logic        ram_cs, ram_r_w;
   logic [15:0] ram_addr, ram_data_in;
   logic        ram_ready = 1'b0;
   logic [15:0] ram_data_out = '0;
   logic        kbd_valid = 1'b0;
   logic [7:0]  kbd_char = '0;
   logic        kbd_irq;
   logic        disp_ready = 1'b0;
   logic        ddr_valid;
   logic [7:0]  ddr_char;
   logic        mcr_run;

   logic [15:0] ram [0:65535];
   logic        ram_hold = 1'b0;

   int total = 0;
   int bad   = 0;

   // results of the last access
   int          lat, cs_cnt, rw_cnt;
   logic [15:0] rd;
   logic        dv;
   logic [7:0]  dc;
   logic [3:0]  rpat;

   lc3_mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_r(mem_r),
      .ram_cs(ram_cs), .ram_r_w(ram_r_w), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
      .ram_ready(ram_ready), .ram_data_out(ram_data_out),
      .kbd_valid(kbd_valid), .kbd_char(kbd_char), .kbd_irq(kbd_irq),
      .disp_ready(disp_ready), .ddr_valid(ddr_valid), .ddr_char(ddr_char),
      .mcr_run(mcr_run)
   );

   always #5 clk = ~clk;

   // RAM: registered ready and read data, pre-write word returned on writes
   always @(posedge clk) begin
      if (ram_cs && !ram_hold) begin
         ram_ready    <= 1'b1;
         ram_data_out <= ram[ram_addr];
         if (ram_r_w) ram[ram_addr] <= ram_data_in;
      end else begin
         ram_ready <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One CPU access; mem_en held until mem_r seen, bounded to 20 cycles
   task automatic acc(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      @(negedge clk);
      mem_en = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
      lat = 0; cs_cnt = 0; rw_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (ram_cs) cs_cnt++;
         if (ram_cs && ram_r_w) rw_cnt++;
      end while (!mem_r && lat < 20);
      rd = mem_rdata; dv = ddr_valid; dc = ddr_char;
      mem_en = 1'b0; mem_we = 1'b0;
   endtask

   task automatic kbd_pulse(input logic [7:0] c);
      @(negedge clk);
      kbd_valid = 1'b1; kbd_char = c;
      @(negedge clk);
      kbd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ram[16'h3000] = 16'h1234;
      repeat (2) @(negedge clk);
      chk("rst_ram_cs", ram_cs, 0);
      chk("rst_ram_r_w", ram_r_w, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_data_in", ram_data_in, 0);
      chk("rst_mem_rdata", mem_rdata, 0);
      chk("rst_mem_r", mem_r, 0);
      chk("rst_ddr_valid", ddr_valid, 0);
      chk("rst_ddr_char", ddr_char, 0);
      chk("rst_kbd_irq", kbd_irq, 0);
      chk("rst_mcr_run", mcr_run, 1);
      rst_n = 1'b1;

      // RAM read
      acc(1'b0, 16'h3000, 16'h0000);
      chk("rd3000_lat", lat, 3);
      chk("rd3000_cs_cycles", cs_cnt, 2);
      chk("rd3000_data", rd, 16'h1234);
      @(negedge clk);
      chk("rd3000_r_one_cycle", mem_r, 0);

      // RAM write then read back
      acc(1'b1, 16'h4000, 16'hABCD);
      chk("wr4000_lat", lat, 3);
      chk("wr4000_rw_cycles", rw_cnt, 2);
      acc(1'b0, 16'h4000, 16'h0000);
      chk("rd4000_data", rd, 16'hABCD);
      chk("rd4000_rw_cycles", rw_cnt, 0);
      chk("rd4000_cs_cycles", cs_cnt, 2);

      // keyboard
      kbd_pulse(8'h41);
      acc(1'b0, 16'hFE00, 16'h0000);
      chk("kbsr_lat", lat, 1);
      chk("kbsr_ready", rd, 16'h8000);
      chk("kbsr_no_cs", cs_cnt, 0);
      acc(1'b0, 16'hFE02, 16'h0000);
      chk("kbdr_41", rd, 16'h0041);
      acc(1'b0, 16'hFE00, 16'h0000);
      chk("kbsr_cleared", rd, 16'h0000);
      acc(1'b1, 16'hFE00, 16'h4000);
      @(negedge clk);
      chk("irq_ie_only", kbd_irq, 0);
      kbd_pulse(8'h42);
      chk("irq_set", kbd_irq, 1);

      // kbd_valid coincident with a KBDR read
      @(negedge clk);
      mem_en = 1'b1; mem_we = 1'b0; mem_addr = 16'hFE02;
      kbd_valid = 1'b1; kbd_char = 8'h43;
      @(negedge clk);
      kbd_valid = 1'b0; mem_en = 1'b0;
      chk("coinc_mem_r", mem_r, 1);
      chk("coinc_old_char", mem_rdata, 16'h0042);
      acc(1'b0, 16'hFE00, 16'h0000);
      chk("coinc_kbsr", rd, 16'hC000);
      acc(1'b0, 16'hFE02, 16'h0000);
      chk("coinc_new_char", rd, 16'h0043);
      acc(1'b0, 16'hFE00, 16'h0000);
      chk("kbsr_ie_only", rd, 16'h4000);
      chk("irq_cleared", kbd_irq, 0);

      // display
      disp_ready = 1'b1;
      acc(1'b1, 16'hFE06, 16'h0048);
      chk("ddr_valid", dv, 1);
      chk("ddr_char", dc, 8'h48);
      @(negedge clk);
      chk("ddr_one_pulse", ddr_valid, 0);
      acc(1'b0, 16'hFE04, 16'h0000);
      chk("dsr_ready", rd, 16'h8000);
      acc(1'b0, 16'hFE06, 16'h0000);
      chk("ddr_read_zero", rd, 16'h0000);
      chk("ddr_no_pulse_on_read", dv, 0);
      disp_ready = 1'b0;
      acc(1'b0, 16'hFE04, 16'h0000);
      chk("dsr_busy", rd, 16'h0000);

      // MCR
      acc(1'b0, 16'hFFFE, 16'h0000);
      chk("mcr_reset_val", rd, 16'h8000);
      acc(1'b1, 16'hFFFE, 16'h1234);
      chk("mcr_run_low", mcr_run, 0);

      // held request: accepted, RESP, re-accepted only from IDLE
      @(negedge clk);
      mem_en = 1'b1; mem_we = 1'b0; mem_addr = 16'hFFFE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rpat[3-i] = mem_r;
      end
      mem_en = 1'b0;
      chk("held_req_pattern", rpat, 4'b1010);
      chk("mcr_readback", mem_rdata, 16'h1234);
      acc(1'b1, 16'hFFFE, 16'h0000);
      chk("mcr_zero_run", mcr_run, 0);

      // stalled RAM, then reset during WAIT
      ram_hold = 1'b1;
      @(negedge clk);
      mem_en = 1'b1; mem_we = 1'b0; mem_addr = 16'h3000;
      @(negedge clk);
      chk("stall_issue_cs", ram_cs, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_cs_held", ram_cs, 1);
         chk("stall_no_r", mem_r, 0);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_cs", ram_cs, 0);
      chk("midrst_mem_r", mem_r, 0);
      chk("midrst_mcr_run", mcr_run, 1);
      chk("midrst_ram_addr", ram_addr, 0);
      mem_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; ram_hold = 1'b0;
      @(negedge clk);
      chk("postrst_no_r", mem_r, 0);
      acc(1'b0, 16'h3000, 16'h0000);
      chk("postrst_lat", lat, 3);
      chk("postrst_data", rd, 16'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory controller between the LC-3 datapath (MAR/MDR) and the 64K-word RAM. Accepts one CPU read or write at a time and decodes the memory-mapped I/O page: KBSR/KBDR, DSR/DDR and MCR are served from local registers, and every other address is forwarded to the RAM over its cs / r_w / ready handshake. Returns read data and a one-cycle completion strobe (the LC-3 "R" signal) to the control FSM.

## Interface
- `DATA_WIDTH`, 16, word width.
- `ADDR_WIDTH`, 16, address width.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_en`  in  1  CPU request. Sampled only in IDLE; held by the CPU until `mem_r`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  ADDR_WIDTH  MAR.
- `mem_wdata`  in  DATA_WIDTH  MDR write data.
- `mem_rdata`  out  DATA_WIDTH  read data; valid while `mem_r`=1.
- `mem_r`  out  1  one-cycle completion strobe.
- `ram_cs`, `ram_r_w`  out  1 each  RAM select; `ram_r_w`=1 means write.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_data_in`  out  DATA_WIDTH  RAM write data.
- `ram_ready`  in  1  registered RAM acknowledge.
- `ram_data_out`  in  DATA_WIDTH  RAM read data.
- `kbd_valid`  in  1  one-cycle pulse: new keyboard character.
- `kbd_char`  in  8  character, valid with `kbd_valid`.
- `kbd_irq`  out  1  KBSR[15] & KBSR[14].
- `disp_ready`  in  1  display sink can accept a character.
- `ddr_valid`  out  1  one-cycle pulse on a DDR write.
- `ddr_char`  out  8  character, valid with `ddr_valid`.
- `mcr_run`  out  1  MCR[15]; 0 halts the machine.

## Operation
- Decode: KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06, MCR xFFFE. All other addresses go to RAM.
- FSM states and transitions:
  - IDLE: on `mem_en`, latch addr / we / wdata. Go to ISSUE for a RAM address, or to RESP for a device address (the device access is performed in that same edge).
  - ISSUE: `ram_cs`=1. Go to WAIT unconditionally; `ram_ready` is ignored here, because it may be stale.
  - WAIT: `ram_cs`=1. On `ram_ready`=1, capture `ram_data_out` into `mem_rdata` and go to RESP.
  - RESP: `mem_r`=1, `ram_cs`=0. Go to IDLE.
- `ram_cs` is decoded from state (ISSUE or WAIT). `ram_addr`, `ram_data_in` and `ram_r_w` come from the latched request.
- `ram_cs` is low for at least two consecutive edges between accesses (RESP, then IDLE), so `ram_ready` is always deasserted before the next ISSUE.
- On a RAM write, `mem_rdata` captures the RAM's pre-write word; the CPU must not use it.
- KBSR:
  - Bit 15 (ready) is set by `kbd_valid`, which also loads `kbd_char` into KBDR[7:0].
  - Bit 15 is cleared by a CPU read of KBDR.
  - Bit 14 (IE) is CPU-writable. A write to KBSR changes only bit 14.
  - Reads return {rdy, ie, 14'b0}.
- KBDR: reads return {8'b0, char}; writes are ignored.
- If `kbd_valid` and a KBDR read occur on the same edge: the new character is latched and ready stays 1 (set wins). The read returns the old character.
- DSR: reads return {`disp_ready`, 15'b0}; writes are ignored.
- DDR: a write drives `ddr_valid`=1 with `ddr_char`=wdata[7:0] during the RESP cycle. Reads return 0.
- MCR: full 16-bit register, reads and writes. `mcr_run`=MCR[15].

## Timing
- Reset values:
  - Outputs: state IDLE, `ram_cs`=0, `ram_r_w`=0, `ram_addr`=0, `ram_data_in`=0, `mem_rdata`=0, `mem_r`=0, `ddr_valid`=0, `ddr_char`=0, `kbd_irq`=0.
  - Registers: KBSR=0, KBDR=0, MCR=x8000 (so `mcr_run`=1).
- RAM access: request accepted at edge E0 → `ram_cs` high in the cycles after E0 and E1 → data captured at E2 → `mem_r` high for the cycle after E2. Total: 3 cycles from acceptance to completion.
- If `ram_ready` is late, WAIT holds `ram_cs` indefinitely. There is no timeout.
- Device access: accepted at E0 → `mem_r` high in the cycle after E0.
- `mem_en` asserted outside IDLE is ignored. A request held through RESP is re-accepted only in IDLE.
- Reset asserted mid-access: immediate return to IDLE and `ram_cs`=0; no `mem_r` is produced.

## Test plan
- Read x3000 with RAM[x3000]=x1234 → `ram_cs` high for exactly 2 cycles; `mem_r` pulses 3 cycles after acceptance with `mem_rdata`=x1234.
- Write xABCD to x4000, then read x4000 → the read returns xABCD; `ram_r_w`=1 only during the write.
- `kbd_valid` with `kbd_char`=x41, then read KBSR → x8000. Read KBDR → x0041, then KBSR → x0000. Write KBSR x4000, then pulse `kbd_valid` → `kbd_irq`=1.
- `kbd_valid` coincident with a KBDR read → the read returns the old character, KBSR[15] stays 1, and KBDR holds the new character.
- Write x0048 to DDR with `disp_ready`=1 → one `ddr_valid` pulse with `ddr_char`=x48; a DSR read returns x8000. Write x0000 to MCR → `mcr_run`=0.
- Hold `ram_ready`=0 for 5 cycles in WAIT → `ram_cs` stays high and `mem_r` stays low. Deassert `rst_n` during WAIT → IDLE immediately, `ram_cs`=0, MCR=x8000.
